conv_loop_ctrl: RTL
===================

CONV_LOOP_CTRL -- requirements
Module: conv_loop_ctrl

Interface
REQ-001 SHALL have parameter MAX_FM_DIM, default 128, largest feature-map width/height.
REQ-002 SHALL have parameter MAX_IN_CH, default 16, largest input channel count.
REQ-003 SHALL have parameter MAX_OUT_CH, default 64, largest output channel count.
REQ-004 SHALL have parameter KERNEL_SIZE, default 3, odd square kernel size.
REQ-005 SHALL have ports, in this order:
- clk  in  1  single clock; all state rises on it.
- arst_n_in  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a layer.
- cfg_fm_width, cfg_fm_height  in  $clog2(MAX_FM_DIM+1)  input map dimensions.
- cfg_in_ch  in  $clog2(MAX_IN_CH+1)  input channel count.
- cfg_out_ch  in  $clog2(MAX_OUT_CH+1)  output channel count.
- cfg_stride  in  2  stride; only 1 and 2 are legal.
- running  out  1  high while a layer is in progress.
- done  out  1  one-cycle pulse at layer end.
- cfg_err  out  1  sticky until next start; high if the latched config was illegal.
- step_valid  out  1  a MAC step is presented.
- step_ready  in  1  datapath accepts the step.
- in_x, in_y  out  $clog2(MAX_FM_DIM)  input coordinate; 0 when padded.
- k_x, k_y  out  $clog2(KERNEL_SIZE)  kernel tap.
- ch_in  out  $clog2(MAX_IN_CH)  input channel index.
- ch_out  out  $clog2(MAX_OUT_CH)  output channel index.
- a_zero  out  1  step lies in zero padding.
- acc_clear  out  1  first step of an output.
- step_last  out  1  last step of an output.
- out_valid  out  1  accumulated output complete.
- out_ready  in  1  sink accepts the output.
- output_x, output_y, output_ch  out  coordinate widths above  tag of the completed output.

Function
REQ-006 SHALL use FSM states IDLE, RUN, DRAIN, DONE.
REQ-007 IDLE: start=1 SHALL latch all cfg_* inputs and go to RUN; if any dimension or channel count is 0, or cfg_stride is not 1/2, SHALL instead set cfg_err and go to DONE.
REQ-008 start SHALL be ignored outside IDLE.
REQ-009 Loop order, outermost to innermost, SHALL be oy, ox, ch_out, k_y, k_x, ch_in.
REQ-010 Output dimensions SHALL be ceil(W/stride) x ceil(H/stride), with "same" padding.
REQ-011 Input coordinate SHALL be ox*stride+k_x-KERNEL_SIZE/2, evaluated signed; when it is outside [0,W-1] or [0,H-1], a_zero=1 and in_x/in_y=0.
REQ-012 The step fields SHALL be held stable while step_valid=1 and step_ready=0; counters SHALL advance only on step_valid&step_ready.
REQ-013 acc_clear SHALL be 1 when k_x=k_y=ch_in=0; step_last SHALL be 1 on the final tap and channel.
REQ-014 The cycle after a handshake with step_last=1, out_valid SHALL rise with output_x/y/ch tagged; it SHALL hold until out_ready=1.
REQ-015 While out_valid=1 and out_ready=0, step_valid SHALL be 0.
REQ-016 After the final step handshake the FSM SHALL go to DRAIN; on out_valid&out_ready it SHALL go to DONE.
REQ-017 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-018 running SHALL be 1 exactly in RUN and DRAIN.

Reset
REQ-019 arst_n_in=0 SHALL immediately force IDLE and drive every output and counter to 0, including mid-layer; cfg_err SHALL clear.

Structure
REQ-020 State enum and a loop-index struct SHALL live in a shared package, as SHALL the derived index widths.
REQ-021 One sub-module, wrap_counter (count 0..limit-1, enable, wrap flag), SHALL be instantiated per loop level.

Verification
REQ-022 W=H=4, Cin=Cout=1, stride 1, step_ready=out_ready=1 -> 144 step handshakes, 16 outputs in raster order; output (0,0) has a_zero on 5 of 9 steps; one done pulse.
REQ-023 W=H=5, stride 2, Cin=2, Cout=2 -> 3x3x2 outputs; output_x sequence 0,1,2; 18 steps per output.
REQ-024 step_ready toggling every cycle, out_ready held low 3 cycles -> step fields are stable during stalls, step_valid=0 during out_valid hold, and no outputs are lost or duplicated.
REQ-025 cfg_in_ch=0 -> no step_valid, done pulse 1 cycle after start, cfg_err=1.
REQ-026 arst_n_in pulsed low mid-RUN -> all outputs are 0 and the FSM is in IDLE; a fresh start then produces the complete REQ-022 sequence.
REQ-027 start pulsed during RUN -> ignored; sequence and output count are unchanged.

Source files
------------

// File: rtl/conv_loop_ctrl_pkg.sv
// Shared types and widths for the convolution loop controller.
// - state_t    : controller FSM states
// - loop_idx_t : one index per loop level, outermost (oy) to innermost (ci)
// - *_IDX_W    : index widths derived from the default design limits
package conv_loop_ctrl_pkg;

    localparam int DEF_MAX_FM_DIM  = 128;
    localparam int DEF_MAX_IN_CH   = 16;
    localparam int DEF_MAX_OUT_CH  = 64;
    localparam int DEF_KERNEL_SIZE = 3;

    // Width of an index that counts 0..n-1; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int FM_IDX_W  = idx_w(DEF_MAX_FM_DIM);
    localparam int ICH_IDX_W = idx_w(DEF_MAX_IN_CH);
    localparam int OCH_IDX_W = idx_w(DEF_MAX_OUT_CH);
    localparam int K_IDX_W   = idx_w(DEF_KERNEL_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [FM_IDX_W-1:0]  oy;
        logic [FM_IDX_W-1:0]  ox;
        logic [OCH_IDX_W-1:0] co;
        logic [K_IDX_W-1:0]   ky;
        logic [K_IDX_W-1:0]   kx;
        logic [ICH_IDX_W-1:0] ci;
    } loop_idx_t;

endpackage

// File: rtl/conv_loop_ctrl_wrap_counter.sv
// One loop level: counts 0..limit-1 while en is high, then wraps to 0.
// - clr   : synchronous return to 0 (start of a layer), wins over en
// - en    : advance this level
// - limit : trip count of this level
// - cnt   : current index
// - wrap  : cnt is on its last value (independent of en, so levels can chain)
module wrap_counter #(
    parameter int CW = 4,
    parameter int LW = 5
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [LW-1:0] limit,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    assign wrap = (32'(cnt) + 32'd1) == 32'(limit);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)   cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (en)   cnt <= wrap ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/conv_loop_ctrl.sv
// Convolution loop controller: walks oy, ox, ch_out, k_y, k_x, ch_in for one
// layer, presenting one MAC step per handshake with "same" zero padding, and
// tags each finished output. Layer config is latched on start.
// Ports:
// - clk, arst_n_in           : clock, async active-low reset
// - start, cfg_*             : layer request and its configuration
// - running, done, cfg_err   : layer status
// - step_valid/step_ready    : MAC step handshake with in_x/in_y, k_x/k_y,
//                              ch_in, ch_out, a_zero, acc_clear, step_last
// - out_valid/out_ready      : completed-output handshake with output_x/y/ch
module conv_loop_ctrl
    import conv_loop_ctrl_pkg::*;
#(
    parameter int MAX_FM_DIM  = DEF_MAX_FM_DIM,
    parameter int MAX_IN_CH   = DEF_MAX_IN_CH,
    parameter int MAX_OUT_CH  = DEF_MAX_OUT_CH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE
) (
    input  logic                            clk,
    input  logic                            arst_n_in,
    input  logic                            start,
    input  logic [$clog2(MAX_FM_DIM+1)-1:0] cfg_fm_width,
    input  logic [$clog2(MAX_FM_DIM+1)-1:0] cfg_fm_height,
    input  logic [$clog2(MAX_IN_CH+1)-1:0]  cfg_in_ch,
    input  logic [$clog2(MAX_OUT_CH+1)-1:0] cfg_out_ch,
    input  logic [1:0]                      cfg_stride,
    output logic                            running,
    output logic                            done,
    output logic                            cfg_err,
    output logic                            step_valid,
    input  logic                            step_ready,
    output logic [$clog2(MAX_FM_DIM)-1:0]   in_x,
    output logic [$clog2(MAX_FM_DIM)-1:0]   in_y,
    output logic [$clog2(KERNEL_SIZE)-1:0]  k_x,
    output logic [$clog2(KERNEL_SIZE)-1:0]  k_y,
    output logic [$clog2(MAX_IN_CH)-1:0]    ch_in,
    output logic [$clog2(MAX_OUT_CH)-1:0]   ch_out,
    output logic                            a_zero,
    output logic                            acc_clear,
    output logic                            step_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(MAX_FM_DIM)-1:0]   output_x,
    output logic [$clog2(MAX_FM_DIM)-1:0]   output_y,
    output logic [$clog2(MAX_OUT_CH)-1:0]   output_ch
);

    localparam int DW  = $clog2(MAX_FM_DIM+1);
    localparam int XW  = $clog2(MAX_FM_DIM);
    localparam int IW  = $clog2(MAX_IN_CH+1);
    localparam int CIW = $clog2(MAX_IN_CH);
    localparam int OW  = $clog2(MAX_OUT_CH+1);
    localparam int COW = $clog2(MAX_OUT_CH);
    localparam int KW  = $clog2(KERNEL_SIZE);
    localparam int PAD = KERNEL_SIZE / 2;

    state_t    state, next_state;
    loop_idx_t idx;

    logic [DW-1:0] w_r, h_r, ow, oh;
    logic [IW-1:0] cin_r;
    logic [OW-1:0] cout_r;
    logic [1:0]    stride_r;
    logic          cfg_ok, accept;

    logic w_oy, w_ox, w_co, w_ky, w_kx, w_ci;
    logic adv, tap_last, layer_last, vld;
    logic out_valid_r;
    int   ix, iy;
    logic pad;

    // ---------------- configuration ----------------
    assign cfg_ok = (cfg_fm_width != '0) && (cfg_fm_height != '0) &&
                    (cfg_in_ch != '0) && (cfg_out_ch != '0) &&
                    (cfg_stride == 2'd1 || cfg_stride == 2'd2);
    assign accept = (state == IDLE) && start;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            w_r      <= '0;
            h_r      <= '0;
            cin_r    <= '0;
            cout_r   <= '0;
            stride_r <= '0;
            cfg_err  <= 1'b0;
        end else if (accept) begin
            w_r      <= cfg_fm_width;
            h_r      <= cfg_fm_height;
            cin_r    <= cfg_in_ch;
            cout_r   <= cfg_out_ch;
            stride_r <= cfg_stride;
            cfg_err  <= !cfg_ok;
        end
    end

    // ceil(dim/stride); only meaningful once a legal config is latched
    assign ow = (stride_r == 2'd2) ? DW'((32'(w_r) + 32'd1) >> 1) : w_r;
    assign oh = (stride_r == 2'd2) ? DW'((32'(h_r) + 32'd1) >> 1) : h_r;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) state <= IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        running    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:    if (start) next_state = cfg_ok ? RUN : DONE;
            RUN: begin
                running = 1'b1;
                if (adv && layer_last) next_state = DRAIN;
            end
            DRAIN: begin
                running = 1'b1;
                if (out_valid_r && out_ready) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // ---------------- loop nest ----------------
    // A new step is offered only while no finished output is waiting, so
    // step_valid never drops without a handshake.
    assign vld        = (state == RUN) && !out_valid_r;
    assign adv        = vld && step_ready;
    assign tap_last   = w_ci && w_kx && w_ky;
    assign layer_last = tap_last && w_co && w_ox && w_oy;

    wrap_counter #(.CW($bits(idx.ci)), .LW(IW)) u_ci (
        .clk(clk), .arst_n(arst_n_in), .clr(accept), .en(adv),
        .limit(cin_r), .cnt(idx.ci), .wrap(w_ci));
    wrap_counter #(.CW($bits(idx.kx)), .LW(KW+1)) u_kx (
        .clk(clk), .arst_n(arst_n_in), .clr(accept), .en(adv && w_ci),
        .limit((KW+1)'(KERNEL_SIZE)), .cnt(idx.kx), .wrap(w_kx));
    wrap_counter #(.CW($bits(idx.ky)), .LW(KW+1)) u_ky (
        .clk(clk), .arst_n(arst_n_in), .clr(accept), .en(adv && w_ci && w_kx),
        .limit((KW+1)'(KERNEL_SIZE)), .cnt(idx.ky), .wrap(w_ky));
    wrap_counter #(.CW($bits(idx.co)), .LW(OW)) u_co (
        .clk(clk), .arst_n(arst_n_in), .clr(accept), .en(adv && tap_last),
        .limit(cout_r), .cnt(idx.co), .wrap(w_co));
    wrap_counter #(.CW($bits(idx.ox)), .LW(DW)) u_ox (
        .clk(clk), .arst_n(arst_n_in), .clr(accept), .en(adv && tap_last && w_co),
        .limit(ow), .cnt(idx.ox), .wrap(w_ox));
    wrap_counter #(.CW($bits(idx.oy)), .LW(DW)) u_oy (
        .clk(clk), .arst_n(arst_n_in), .clr(accept), .en(adv && tap_last && w_co && w_ox),
        .limit(oh), .cnt(idx.oy), .wrap(w_oy));

    // ---------------- step fields ----------------
    // Signed input coordinate; anything outside the map is zero padding.
    always_comb begin
        ix  = int'(idx.ox) * int'(stride_r) + int'(idx.kx) - PAD;
        iy  = int'(idx.oy) * int'(stride_r) + int'(idx.ky) - PAD;
        pad = (ix < 0) || (ix >= int'(w_r)) || (iy < 0) || (iy >= int'(h_r));
    end

    // Fields are forced to 0 whenever no step is offered (idle, reset).
    assign step_valid = vld;
    assign in_x       = (vld && !pad) ? XW'(ix) : '0;
    assign in_y       = (vld && !pad) ? XW'(iy) : '0;
    assign k_x        = vld ? KW'(idx.kx) : '0;
    assign k_y        = vld ? KW'(idx.ky) : '0;
    assign ch_in      = vld ? CIW'(idx.ci) : '0;
    assign ch_out     = vld ? COW'(idx.co) : '0;
    assign a_zero     = vld && pad;
    assign acc_clear  = vld && (idx.kx == '0) && (idx.ky == '0) && (idx.ci == '0);
    assign step_last  = vld && tap_last;

    // ---------------- completed output ----------------
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            out_valid_r <= 1'b0;
            output_x    <= '0;
            output_y    <= '0;
            output_ch   <= '0;
        end else if (adv && tap_last) begin
            out_valid_r <= 1'b1;
            output_x    <= XW'(idx.ox);
            output_y    <= XW'(idx.oy);
            output_ch   <= COW'(idx.co);
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;

endmodule
